i2s_adc_receiver: RTL and testbench
===================================

Name: i2s_adc_receiver

Overview:
- Deserialises the WM8731 ADC stream (AUD_ADCDAT framed by AUD_ADCLRCK, clocked by AUD_BCLK) into parallel PCM words in the system clk domain.
- Sits directly downstream of the codec pins. It feeds the recorder/memory-write stage through a valid/ready handshake.
- The codec runs as master in I2S mode: MSB on the 2nd BCLK rising edge after an LRCK transition, LRCK low = left.
- BCLK is oversampled by clk; no BCLK-domain logic.

Parameters:
- DATA_WIDTH, 16: bits per channel word.
- SYNC_STAGES, 2: synchroniser flops on AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT (minimum 2).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- AUD_BCLK  input  1  codec bit clock (asynchronous to clk; at most clk/8).
- AUD_ADCLRCK  input  1  ADC frame clock; 0 = left, 1 = right.
- AUD_ADCDAT  input  1  ADC serial data, MSB first.
- enable  input  1  1 = receive; 0 = abandon the current frame and idle.
- o_data  output  DATA_WIDTH  received word.
- o_channel  output  1  channel of o_data (0 left, 1 right).
- o_valid  output  1  o_data/o_channel hold a word not yet accepted.
- i_ready  input  1  consumer accepts the word when o_valid & i_ready.
- o_overrun  output  1  sticky: a completed word was dropped.
- o_short_frame  output  1  one-clk pulse: LRCK toggled before DATA_WIDTH bits were captured.

Behaviour:
- Reset values (reset low, asynchronous): o_data=0, o_channel=0, o_valid=0, o_overrun=0, o_short_frame=0. Synchronisers, shift register and bit counter clear; FSM goes to IDLE.
- Synchronisation:
  - All three codec inputs pass through SYNC_STAGES flops.
  - bclk_rise = synced BCLK is 1 this cycle and was 0 last cycle.
  - LRCK and DAT are sampled only on cycles where bclk_rise is high.
  - lr_edge = sampled LRCK differs from the previous sampled LRCK.
- FSM:
  - IDLE: wait for enable=1 and an lr_edge; go to SKIP and latch channel = new LRCK value.
  - SKIP: consume exactly one bclk_rise (the I2S delay bit), then go to SHIFT with count=0.
  - SHIFT:
    - On each bclk_rise, shift DAT in at the LSB and increment count.
    - On the bclk_rise capturing bit DATA_WIDTH-1, publish the word at that same clk edge and go to HOLD.
  - HOLD: ignore further bits; on lr_edge go to SKIP with the new channel.
  - lr_edge in SKIP or SHIFT (short frame):
    - Discard the partial word and pulse o_short_frame for 1 clk.
    - Go to SKIP with the new channel.
  - enable=0 in any state: go to IDLE on the next clk and discard the partial word. o_data/o_valid/o_overrun are unchanged, and the handshake continues to work.
- Publish rules (at the publishing edge):
  - If o_valid=0, or o_valid & i_ready in the same cycle: load o_data/o_channel and set o_valid=1. Back-to-back acceptance never overruns.
  - If o_valid=1 & i_ready=0: the new word is dropped, the held word is kept, and o_overrun is set.
- Handshake:
  - o_valid clears on the clk after o_valid & i_ready, unless a publish occurs on that same edge.
  - o_data and o_channel stay stable while o_valid=1 & i_ready=0.
- o_overrun clears only on reset.
- Latency: the pin-to-o_valid delay for the LSB is SYNC_STAGES+1 clk after the BCLK rising edge.
- Words longer than DATA_WIDTH on the wire: extra LSBs are ignored in HOLD.
- The first frame after reset or after enable rises is never published, because an lr_edge is needed to align.

Test Plan:
- BCLK = clk/16, 32-bit LRCK half-frames, left=16'hA5C3, right=16'h1234, i_ready=1 -> words (0,A5C3) then (1,1234), each o_valid for exactly 1 clk; o_overrun=0.
- Same stream with i_ready=0 for two frames -> o_valid stays 1 holding (0,A5C3); o_overrun=1 after the second word completes; o_data unchanged.
- LRCK toggles after 10 data bits of a left word -> o_short_frame pulses once, no o_valid; the following right word 16'h00FF is received correctly.
- reset driven low mid-SHIFT (bit 7), released, stream continues -> all outputs 0 during reset; the first published word is the one after the next full LRCK edge.
- enable dropped mid-word, then raised -> the partial word is never published; after the next lr_edge, 16'h8001 is received intact.
- i_ready asserted on the same clk as the LSB publish with o_valid=1 -> new word loaded, o_valid stays 1, o_overrun stays 0.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// WM8731 I2S ADC receiver: oversamples the codec pins in the clk domain and
// presents one PCM word per channel through a valid/ready handshake.
module i2s_adc_receiver #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_channel,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overrun,
    output logic                  o_short_frame
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StShift,
        StHold
    } state_e;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   lrck_smp_q, lrck_smp_d;
    logic                   primed_q, primed_d;
    state_e                 state_q, state_d;
    logic                   chan_q, chan_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   ch_out_q, ch_out_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   short_q, short_d;

    logic                   bclk_s, lrck_s, dat_s;
    logic                   bclk_rise, lr_edge, publish;
    logic [DATA_WIDTH-1:0]  word;

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev_q;
    // No edge is reported until a first LRCK sample exists to compare against.
    assign lr_edge   = bclk_rise & primed_q & (lrck_s ^ lrck_smp_q);
    assign word      = {shift_q[DATA_WIDTH-2:0], dat_s};

    always_comb begin : sync_next
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
        bclk_prev_d = bclk_s;
        lrck_smp_d  = lrck_smp_q;
        primed_d    = primed_q;
        if (bclk_rise) begin
            lrck_smp_d = lrck_s;
            primed_d   = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        publish = 1'b0;
        short_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lr_edge) begin
                        state_d = StSkip;
                        chan_d  = lrck_s;
                    end
                end
                StSkip: begin
                    if (lr_edge) begin
                        short_d = 1'b1;
                        chan_d  = lrck_s;
                    end else if (bclk_rise) begin
                        state_d = StShift;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                StShift: begin
                    if (lr_edge) begin
                        short_d = 1'b1;
                        state_d = StSkip;
                        chan_d  = lrck_s;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else if (bclk_rise) begin
                        shift_d = word;
                        cnt_d   = cnt_q + CntW'(1);
                        if (cnt_q == LastBit) begin
                            publish = 1'b1;
                            state_d = StHold;
                            cnt_d   = '0;
                        end
                    end
                end
                StHold: begin
                    if (lr_edge) begin
                        state_d = StSkip;
                        chan_d  = lrck_s;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin : out_next
        data_d    = data_q;
        ch_out_d  = ch_out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (publish) begin
            // A word accepted on this same edge frees the slot for the new one.
            if (!valid_q || i_ready) begin
                data_d   = word;
                ch_out_d = chan_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            lrck_smp_q  <= 1'b0;
            primed_q    <= 1'b0;
            state_q     <= StIdle;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ch_out_q    <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            dat_sync_q  <= dat_sync_d;
            bclk_prev_q <= bclk_prev_d;
            lrck_smp_q  <= lrck_smp_d;
            primed_q    <= primed_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ch_out_q    <= ch_out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            short_q     <= short_d;
        end
    end

    assign o_data        = data_q;
    assign o_channel     = ch_out_q;
    assign o_valid       = valid_q;
    assign o_overrun     = overrun_q;
    assign o_short_frame = short_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: drives a codec-style I2S stream (BCLK = clk/16)
// and checks received words against a queue of words the stream should yield.
module tb_i2s_adc_receiver;

    localparam int unsigned Dw = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          AUD_BCLK;
    logic          AUD_ADCLRCK;
    logic          AUD_ADCDAT;
    logic          enable;
    logic [Dw-1:0] o_data;
    logic          o_channel;
    logic          o_valid;
    logic          i_ready;
    logic          o_overrun;
    logic          o_short_frame;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int vcyc = 0;
    int short_cnt = 0;

    // Words the receiver must hand over, in order: {channel, data}.
    logic [Dw:0] exp_q[$];

    i2s_adc_receiver #(
        .DATA_WIDTH (Dw),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .enable       (enable),
        .o_data       (o_data),
        .o_channel    (o_channel),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_overrun    (o_overrun),
        .o_short_frame(o_short_frame)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Consumer side: every accepted word must be the next one in exp_q.
    always begin
        logic [31:0] e;
        @(negedge clk);
        #1;
        if (reset === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
            check_eq("word", {15'b0, o_channel, o_data}, e);
            acc_cnt++;
        end
        if (o_valid === 1'b1) vcyc++;
        if (o_short_frame === 1'b1) short_cnt++;
    end

    // One LRCK half-frame of `periods` BCLK periods. LRCK changes with BCLK
    // rising, data changes on BCLK falling; the MSB is therefore sampled on
    // the 2nd rising edge after the LRCK change, the LSB on the 17th.
    task automatic send_half(input logic lr, input logic [Dw-1:0] w, input int periods,
                             input int rst_at, input int en_off_at, input int en_on_at,
                             input bit rdy_pulse);
        for (int j = 0; j < periods; j++) begin
            AUD_BCLK    = 1'b1;
            AUD_ADCLRCK = lr;
            if (rdy_pulse && j == Dw + 1) begin
                // Ready for exactly the cycle before the LSB publish edge.
                repeat (2) @(negedge clk);
                i_ready = 1'b1;
                @(negedge clk);
                i_ready = 1'b0;
                repeat (5) @(negedge clk);
            end else if (j == rst_at) begin
                repeat (4) @(negedge clk);
                reset = 1'b0;
                #1;
                check_eq("rst_mid_data", 32'(o_data), 32'h0);
                check_eq("rst_mid_chan", 32'(o_channel), 32'h0);
                check_eq("rst_mid_valid", 32'(o_valid), 32'h0);
                check_eq("rst_mid_ovr", 32'(o_overrun), 32'h0);
                check_eq("rst_mid_short", 32'(o_short_frame), 32'h0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            if (j == en_off_at) enable = 1'b0;
            if (j == en_on_at) enable = 1'b1;
            AUD_BCLK   = 1'b0;
            AUD_ADCDAT = (j >= 1 && j <= Dw) ? w[Dw-j] : 1'($urandom_range(0, 1));
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic send_std(input logic lr, input logic [Dw-1:0] w);
        send_half(lr, w, 32, -1, -1, -1, 1'b0);
    endtask

    initial begin
        logic [Dw-1:0] w1, w2;
        int acc0, v0, sh0;
        reset       = 1'b0;
        enable      = 1'b1;
        i_ready     = 1'b1;
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = 1'b0;
        AUD_ADCDAT  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_data", 32'(o_data), 32'h0);
        check_eq("rst_chan", 32'(o_channel), 32'h0);
        check_eq("rst_valid", 32'(o_valid), 32'h0);
        check_eq("rst_ovr", 32'(o_overrun), 32'h0);
        check_eq("rst_short", 32'(o_short_frame), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Basic stream; the leading left half has no LRCK edge to align on.
        acc0 = acc_cnt; v0 = vcyc;
        w1 = 16'($urandom);
        send_std(1'b0, 16'($urandom));
        exp_q.push_back({1'b1, w1});
        send_std(1'b1, w1);
        exp_q.push_back({1'b0, 16'hA5C3});
        send_std(1'b0, 16'hA5C3);
        exp_q.push_back({1'b1, 16'h1234});
        send_std(1'b1, 16'h1234);
        check_eq("basic_acc", 32'(acc_cnt - acc0), 32'd3);
        check_eq("basic_vcyc", 32'(vcyc - v0), 32'd3);
        check_eq("basic_ovr", 32'(o_overrun), 32'h0);

        // Accept on the very edge a new word is published.
        i_ready = 1'b0;
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        exp_q.push_back({1'b0, w1});
        send_std(1'b0, w1);
        exp_q.push_back({1'b1, w2});
        send_half(1'b1, w2, 32, -1, -1, -1, 1'b1);
        check_eq("same_clk_valid", 32'(o_valid), 32'h1);
        check_eq("same_clk_word", {15'b0, o_channel, o_data}, {15'b0, 1'b1, w2});
        check_eq("same_clk_ovr", 32'(o_overrun), 32'h0);
        i_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("same_clk_drain", 32'(o_valid), 32'h0);

        // Consumer stalled for two frames.
        acc0 = acc_cnt;
        i_ready = 1'b0;
        exp_q.push_back({1'b0, 16'hA5C3});
        send_std(1'b0, 16'hA5C3);
        check_eq("stall_ovr_first", 32'(o_overrun), 32'h0);
        check_eq("stall_valid_first", 32'(o_valid), 32'h1);
        send_std(1'b1, 16'h1234);
        check_eq("stall_valid", 32'(o_valid), 32'h1);
        check_eq("stall_word", {15'b0, o_channel, o_data}, {15'b0, 1'b0, 16'hA5C3});
        check_eq("stall_ovr", 32'(o_overrun), 32'h1);
        i_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("stall_acc", 32'(acc_cnt - acc0), 32'd1);

        // Short left frame: 10 data bits, then LRCK toggles.
        acc0 = acc_cnt; sh0 = short_cnt;
        send_half(1'b0, 16'($urandom), 12, -1, -1, -1, 1'b0);
        exp_q.push_back({1'b1, 16'h00FF});
        send_std(1'b1, 16'h00FF);
        check_eq("short_pulses", 32'(short_cnt - sh0), 32'd1);
        check_eq("short_acc", 32'(acc_cnt - acc0), 32'd1);

        // Reset in the middle of a left word.
        acc0 = acc_cnt;
        send_half(1'b0, 16'($urandom), 32, 9, -1, -1, 1'b0);
        w1 = 16'($urandom);
        exp_q.push_back({1'b1, w1});
        send_std(1'b1, w1);
        check_eq("post_rst_acc", 32'(acc_cnt - acc0), 32'd1);
        check_eq("post_rst_ovr", 32'(o_overrun), 32'h0);

        // Enable dropped mid-word, restored before the next LRCK edge.
        acc0 = acc_cnt;
        send_half(1'b0, 16'($urandom), 32, -1, 8, 12, 1'b0);
        exp_q.push_back({1'b1, 16'h8001});
        send_std(1'b1, 16'h8001);
        check_eq("enable_acc", 32'(acc_cnt - acc0), 32'd1);

        // Random back-to-back frames.
        acc0 = acc_cnt;
        for (int k = 0; k < 6; k++) begin
            w1 = 16'($urandom);
            exp_q.push_back({1'(k % 2), w1});
            send_std(1'(k % 2), w1);
        end
        check_eq("rand_acc", 32'(acc_cnt - acc0), 32'd6);

        repeat (20) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
